// File: rtl/softex_out_packer.sv
// Compacts variable-occupancy datapath beats into dense full-width store beats,
// closing each job with one strobed partial beat and a done pulse.
module softex_out_packer #(
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned ELEM_WIDTH = 16,
   localparam int unsigned N_ELEM = DATA_WIDTH / ELEM_WIDTH,
   localparam int unsigned CNT_W  = $clog2(N_ELEM + 1)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    clear_i,
   input  logic                    start_i,
   input  logic [31:0]             tot_len_i,
   output logic                    busy_o,
   output logic                    done_o,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [DATA_WIDTH-1:0]   in_data_i,
   input  logic [CNT_W-1:0]        in_cnt_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [DATA_WIDTH-1:0]   out_data_o,
   output logic [DATA_WIDTH/8-1:0] out_strb_o
);

   localparam int unsigned ACC_W  = 2 * DATA_WIDTH;
   localparam int unsigned FILL_W = $clog2(2 * N_ELEM + 1);
   localparam int unsigned BPE    = ELEM_WIDTH / 8;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PACK  = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [31:0]       rem_q, rem_d;
   logic [ACC_W-1:0]  acc_q, acc_d;

   logic                  in_hs, out_hs, fill_full;
   logic [CNT_W-1:0]      cnt_sat, eff;
   logic [FILL_W-1:0]     shift_amt, base;
   logic [DATA_WIDTH-1:0] in_masked;
   logic [ACC_W-1:0]      acc_shifted, ins_vec;

   assign fill_full   = (fill_q >= FILL_W'(N_ELEM));
   assign in_ready_o  = (state_q == S_PACK) && (fill_q <= FILL_W'(N_ELEM)) && (rem_q != 32'd0);
   assign out_valid_o = fill_full || ((state_q == S_FLUSH) && (fill_q != '0));
   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = (state_q == S_DONE);

   assign in_hs  = in_valid_i && in_ready_o;
   assign out_hs = out_valid_o && out_ready_i;

   // Oversized counts saturate to a full beat; the tail of the job is trimmed to rem.
   assign cnt_sat = (in_cnt_i > CNT_W'(N_ELEM)) ? CNT_W'(N_ELEM) : in_cnt_i;
   assign eff     = (rem_q < 32'(cnt_sat)) ? rem_q[CNT_W-1:0] : cnt_sat;

   generate
      for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_elem
         assign in_masked[gi*ELEM_WIDTH +: ELEM_WIDTH] =
            (CNT_W'(gi) < eff) ? in_data_i[gi*ELEM_WIDTH +: ELEM_WIDTH] : '0;
         assign out_data_o[gi*ELEM_WIDTH +: ELEM_WIDTH] =
            (FILL_W'(gi) < fill_q) ? acc_q[gi*ELEM_WIDTH +: ELEM_WIDTH] : '0;
      end
      for (genvar gb = 0; gb < DATA_WIDTH / 8; gb++) begin : g_strb
         assign out_strb_o[gb] = fill_full || (32'(gb) < 32'(fill_q) * BPE);
      end
   endgenerate

   always_comb begin
      shift_amt   = out_hs ? (fill_full ? FILL_W'(N_ELEM) : fill_q) : '0;
      base        = fill_q - shift_amt;
      acc_shifted = acc_q >> (32'(shift_amt) * ELEM_WIDTH);
      // New elements append behind whatever survives this cycle's output shift.
      ins_vec     = {{DATA_WIDTH{1'b0}}, in_masked} << (32'(base) * ELEM_WIDTH);

      state_d = state_q;
      fill_d  = fill_q;
      rem_d   = rem_q;
      acc_d   = acc_q;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               rem_d   = tot_len_i;
               state_d = (tot_len_i != 32'd0) ? S_PACK : S_DONE;
            end
         end
         S_PACK, S_FLUSH: begin
            acc_d  = acc_shifted | (in_hs ? ins_vec : '0);
            fill_d = base + (in_hs ? FILL_W'(eff) : '0);
            if (in_hs) begin
               rem_d = rem_q - 32'(eff);
            end
            if (state_q == S_PACK) begin
               if (rem_d == 32'd0) begin
                  state_d = S_FLUSH;
               end
            end else if (fill_d == '0) begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (clear_i) begin
         state_d = S_IDLE;
         fill_d  = '0;
         rem_d   = 32'd0;
         acc_d   = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         fill_q  <= '0;
         rem_q   <= 32'd0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         rem_q   <= rem_d;
         acc_q   <= acc_d;
      end
   end

endmodule
